// File: rtl/pipe_add_multi.sv
// N-bit add/subtract pipelined as S = N/SEG stages of SEG-bit ripple segments with registered inter-segment carry.
// Latency: S cycles from accept to out_valid; throughput one beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready; on a stall every stage register holds its value.
module pipe_add_multi #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         ovf
);
    localparam int S = N / SEG;

    generate
        if (N % SEG != 0) begin : g_bad_seg
            $error("pipe_add_multi: N must be a multiple of SEG");
        end
    endgenerate

    logic         adv;
    logic [S-1:0] vld;
    logic [S-1:0] cy;
    logic [N-1:0] ps [S];
    logic [N-1:0] ad [S];
    logic [N-1:0] bd [S];
    logic         ovf_q;

    // Stage inputs: stage 0 takes the conditioned beat, stage k takes stage k-1's registers.
    logic [S-1:0] sv;
    logic [S-1:0] sc;
    logic [N-1:0] sa [S];
    logic [N-1:0] sb [S];
    logic [N-1:0] sp [S];
    logic [N-1:0] np [S];
    logic [SEG:0] seg [S];
    logic         ovf_d;

    assign adv      = !vld[S-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        sv    = '0;
        sc    = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < S; k++) begin
            sa[k]  = '0;
            sb[k]  = '0;
            sp[k]  = '0;
            np[k]  = '0;
            seg[k] = '0;
        end

        sv[0] = in_valid;
        sa[0] = a;
        sb[0] = sub ? ~b : b;
        sc[0] = sub ? ~cin : cin;
        for (int k = 1; k < S; k++) begin
            sv[k] = vld[k-1];
            sc[k] = cy[k-1];
            sa[k] = ad[k-1];
            sb[k] = bd[k-1];
            sp[k] = ps[k-1];
        end

        for (int k = 0; k < S; k++) begin
            seg[k] = {1'b0, sa[k][k*SEG +: SEG]} + {1'b0, sb[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, sc[k]};
            np[k] = sp[k];
            np[k][k*SEG +: SEG] = seg[k][SEG-1:0];
        end

        // Carry into the MSB recovered from a^b^sum at that bit, then XORed with carry-out.
        ovf_d = sa[S-1][N-1] ^ sb[S-1][N-1] ^ np[S-1][N-1] ^ seg[S-1][SEG];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            cy    <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < S; k++) begin
                ps[k] <= '0;
                ad[k] <= '0;
                bd[k] <= '0;
            end
        end else if (adv) begin
            vld <= sv;
            // Data only moves with a valid beat so outputs hold through bubbles.
            for (int k = 0; k < S; k++) begin
                if (sv[k]) begin
                    cy[k] <= seg[k][SEG];
                    ps[k] <= np[k];
                    ad[k] <= sa[k];
                    bd[k] <= sb[k];
                end
            end
            if (sv[S-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = vld[S-1];
    assign sum       = ps[S-1];
    assign carry     = cy[S-1];
    assign ovf       = ovf_q;

endmodule
